// File: rtl/ff_write_arbiter_pkg.sv
// Shared definitions for the enable flip-flop write arbiter.
//   state_t      : arbiter state encoding (2'd3 is unused and recovers to IDLE)
//   DEF_*        : default parameter values for NREQ / WIDTH / CNTW
//   MAX_NREQ     : largest supported requester count
//   rr_pick()    : round-robin winner search starting at a pointer
package ff_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNTW  = 8;
  localparam int MAX_NREQ  = 8;

  // First set bit of req[nreq-1:0] found by scanning ptr, ptr+1, ... wrapping
  // at nreq. ptr must be below nreq. Returns 0 when no bit is set; callers
  // qualify the result with |req.
  function automatic logic [2:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                         input logic [2:0] ptr,
                                         input logic [3:0] nreq);
    logic [2:0] idx;
    logic       found;
    logic [3:0] sum;
    logic [2:0] pos;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      // ptr and k are both below nreq, so a single subtraction wraps the sum.
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= nreq) begin
        sum = sum - nreq;
      end
      pos = sum[2:0];
      if ((4'(k) < nreq) && !found && req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/ff_write_arbiter_if.sv
// Requester-side handshake bundle for the write arbiter.
//   req  : per-requester level request, held until ack or abandon
//   data : flattened write data, requester i on [i*WIDTH +: WIDTH]
//   gnt  : one-hot grant (registered)
//   ack  : one-cycle pulse when the granted data has been stored
// Modports: master = requester side, slave = arbiter side.
interface ff_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  ack;

  modport master (output req, output data, input gnt, input ack);
  modport slave  (input req, input data, output gnt, output ack);
endinterface

// File: rtl/ff_enable_reg.sv
// WIDTH-bit D flip-flop with load enable.
//   clock : rising-edge clock
//   reset : asynchronous active-low clear
//   en    : load d into q on the next rising edge
//   d     : data in
//   q     : stored value
module ff_enable_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ff_write_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one enable flip-flop
// register. Each transaction is IDLE (arbitrate) -> GRANT (write) -> ACK.
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset
//   bus      : requester handshake (req/data in, gnt/ack out)
//   owner    : index of the last requester whose write completed
//   busy     : high while in GRANT or ACK
//   q        : stored register value
//   wr_count : completed writes, wrapping modulo 2^CNTW
module ff_write_arbiter
  import ff_write_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  ff_write_arbiter_if.slave bus,
  output logic [IW-1:0]     owner,
  output logic              busy,
  output logic [WIDTH-1:0]  q,
  output logic [CNTW-1:0]   wr_count
);

  state_t            state_reg;
  logic [IW-1:0]     ptr_reg;
  logic [IW-1:0]     win_reg;
  logic [NREQ-1:0]   gnt_reg;
  logic              ack_reg;
  logic              busy_reg;
  logic [IW-1:0]     owner_reg;
  logic [CNTW-1:0]   cnt_reg;

  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     ptr_next;
  logic              wr_en;
  logic [WIDTH-1:0]  wr_d;

  assign pick_idx = IW'(rr_pick(8'(bus.req), 3'(ptr_reg), 4'(NREQ)));
  assign ptr_next = (win_reg == IW'(NREQ - 1)) ? '0 : win_reg + 1'b1;

  // The register loads only while the granted requester still holds req;
  // dropping req in GRANT abandons the transaction with q untouched.
  assign wr_en = (state_reg == ST_GRANT) && bus.req[win_reg];
  assign wr_d  = bus.data[win_reg*WIDTH +: WIDTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      gnt_reg   <= '0;
      ack_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      owner_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|bus.req) begin
            state_reg <= ST_GRANT;
            win_reg   <= pick_idx;
            gnt_reg   <= NREQ'(1) << pick_idx;
            busy_reg  <= 1'b1;
          end else begin
            gnt_reg   <= '0;
          end
        end
        ST_GRANT: begin
          if (wr_en) begin
            state_reg <= ST_ACK;
            owner_reg <= win_reg;
            cnt_reg   <= cnt_reg + 1'b1;
            ptr_reg   <= ptr_next;
            ack_reg   <= 1'b1;
          end else begin
            // Abandon: pointer stays, so the next search restarts from it.
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end
        end
        ST_ACK: begin
          state_reg <= ST_IDLE;
          gnt_reg   <= '0;
          ack_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          gnt_reg   <= '0;
          ack_reg   <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  ff_enable_reg #(
    .WIDTH (WIDTH)
  ) u_reg (
    .clock (clock),
    .reset (reset),
    .en    (wr_en),
    .d     (wr_d),
    .q     (q)
  );

  assign bus.gnt  = gnt_reg;
  assign bus.ack  = ack_reg;
  assign busy     = busy_reg;
  assign owner    = owner_reg;
  assign wr_count = cnt_reg;

endmodule

// File: tb/tb_ff_write_arbiter.sv
// Scoreboard bench for ff_write_arbiter: the driver issues transactions and
// pushes the expected grant/write results computed from a transaction-level
// round-robin model; an independent monitor pops and compares on each grant
// and ack seen at the DUT outputs.
module tb_ff_write_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int CNTW  = 8;
  localparam int IW    = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ff_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  logic [IW-1:0]    owner;
  logic             busy;
  logic [WIDTH-1:0] q;
  logic [CNTW-1:0]  wr_count;

  ff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .owner    (owner),
    .busy     (busy),
    .q        (q),
    .wr_count (wr_count)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    int               own;
    logic [CNTW-1:0]  cnt;
  } wr_t;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_gnt_q[$];
  wr_t exp_wr_q[$];

  // Transaction-level reference state.
  int              m_ptr = 0;
  logic [CNTW-1:0] m_cnt = '0;
  logic [WIDTH-1:0] m_q  = '0;
  int              total_writes = 0;
  bit              mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Monitor
  logic [NREQ-1:0]  prev_gnt = '0;
  logic [WIDTH-1:0] mon_q    = '0;
  always @(negedge clock) begin
    if (mon_en) begin
      check("gnt_onehot_busy", {30'd0, busy, $onehot0(bus.gnt)}, {30'd0, (bus.gnt != '0), 1'b1});
      if (bus.gnt != '0 && prev_gnt == '0) begin
        check("gnt_expected", (exp_gnt_q.size() != 0), 1);
        if (exp_gnt_q.size() != 0) begin
          int w;
          w = exp_gnt_q.pop_front();
          check("gnt", bus.gnt, 32'(1) << w);
          $display("grant   gnt=%b expected_w=%0d", bus.gnt, w);
        end
      end
      if (bus.ack) begin
        check("ack_expected", (exp_wr_q.size() != 0), 1);
        if (exp_wr_q.size() != 0) begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check("q", q, e.d);
          check("owner", owner, e.own);
          check("wr_count", wr_count, e.cnt);
          $display("write   q=%h owner=%0d wr_count=%0d", q, owner, wr_count);
          mon_q = e.d;
        end
      end else begin
        check("q_hold", q, mon_q);
      end
      prev_gnt = bus.gnt;
    end
  end

  task automatic idle(input int n);
    bus.req = '0;
    repeat (n) @(negedge clock);
  endtask

  // Issue one transaction; called at a negedge. lat = edges until gnt.
  task automatic do_round(input logic [NREQ-1:0] mask, input logic [NREQ*WIDTH-1:0] dat,
                          input bit abandon, input bit scramble, output int lat);
    int w;
    int n;
    logic [NREQ-1:0] r;
    logic [NREQ*WIDTH-1:0] nd;
    bus.req  = mask;
    bus.data = dat;
    w = model_pick(mask);
    exp_gnt_q.push_back(w);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(bus.gnt != '0 && !bus.ack) && n < 10);
    lat = n;
    if (n >= 10) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: no grant within %0d cycles for req=%b", n, mask);
      void'(exp_gnt_q.pop_back());
      bus.req = '0;
      return;
    end
    if (abandon) begin
      bus.req = '0;
      @(negedge clock);
      check("abandon_idle", {bus.ack, bus.gnt}, 0);
    end else begin
      m_cnt = m_cnt + 1'b1;
      m_q   = dat[w*WIDTH +: WIDTH];
      m_ptr = (w + 1) % NREQ;
      total_writes++;
      exp_wr_q.push_back('{m_q, w, m_cnt});
      if (scramble) begin
        r = NREQ'($urandom);
        r[w] = 1'b1;
        nd = (NREQ*WIDTH)'($urandom);
        nd[w*WIDTH +: WIDTH] = dat[w*WIDTH +: WIDTH];
        bus.req  = r;
        bus.data = nd;
      end
      @(negedge clock);
      check("ack_latency", bus.ack, 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [NREQ*WIDTH-1:0] dat;
    logic [NREQ-1:0] mask;
    bit ab;

    // Reset held with every requester asking.
    bus.req  = 4'b1111;
    bus.data = 16'hD963;
    #1;
    check("rst_q", q, 0);
    check("rst_gnt", bus.gnt, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_owner", owner, 0);
    repeat (2) @(negedge clock);
    check("rst_gnt_clocked", bus.gnt, 0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Contention: data3..0 = D,9,6,3; expect 0,1,2,3,0,... one write per 3 cycles.
    do_round(4'b1111, 16'hD963, 1'b0, 1'b0, lat);
    check("release_latency", lat, 1);
    for (int i = 1; i < 8; i++) begin
      do_round(4'b1111, 16'hD963, 1'b0, 1'b0, lat);
      check("contention_latency", lat, 2);
    end
    idle(3);

    // Single write from requester 1.
    do_round(4'b0010, 16'h00B0, 1'b0, 1'b0, lat);
    check("single_latency", lat, 1);
    bus.req = '0;
    @(negedge clock);
    check("single_release", {busy, bus.ack, bus.gnt}, 0);
    idle(2);

    // Abandon while gnt=0100, then the search restarts from the same pointer.
    do_round(4'b0100, 16'h0A00, 1'b1, 1'b0, lat);
    do_round(4'b1111, 16'h1234, 1'b0, 1'b0, lat);
    check("after_abandon_latency", lat, 1);
    idle(2);

    // Randomized traffic, enough writes to wrap the counter.
    for (int i = 0; i < 320; i++) begin
      mask = NREQ'($urandom_range(1, 15));
      dat  = (NREQ*WIDTH)'($urandom);
      ab   = ($urandom_range(0, 5) == 0);
      do_round(mask, dat, ab, 1'($urandom_range(0, 1)), lat);
      if (!ab && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      else if (!ab) bus.req = '0 | bus.req;
    end
    idle(4);
    check("wrap_seen", (total_writes >= 256), 1);
    check("wrap_count", wr_count, total_writes % 256);
    check("last_q", q, m_q);
    check("queues_drained", exp_gnt_q.size() + exp_wr_q.size(), 0);
    mon_en = 1'b0;

    // Asynchronous reset in the middle of ACK.
    bus.req  = 4'b1000;
    bus.data = 16'h7000;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!bus.ack && lat < 10);
    check("pre_reset_ack", bus.ack, 1);
    check("pre_reset_q", q, 4'h7);
    #2 reset = 1'b0;
    #1;
    check("async_q", q, 0);
    check("async_gnt", bus.gnt, 0);
    check("async_ack", bus.ack, 0);
    check("async_busy", busy, 0);
    check("async_wr_count", wr_count, 0);
    $display("async reset mid-ack q=%h gnt=%b ack=%b", q, bus.gnt, bus.ack);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ff_write_arbiter.md
Name: ff_write_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit enable flip-flop register between NREQ requesters.
- Each requester raises req with its data. The arbiter grants one requester at a time, pulses the register enable to capture that requester's data, and acknowledges the write.
- Sits in front of the lab's enable flip-flop storage, sequencing all writes to it, and exposes the stored value and current owner.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, stored data width in bits
- CNTW, 8, width of the completed-write counter

Ports:
- clock  in  1  single system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- req  in  NREQ  request per requester; level, held until ack or abandon
- data  in  NREQ*WIDTH  flattened data; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant; registered
- ack  out  1  one-cycle pulse: granted data has been written into q
- owner  out  $clog2(NREQ)  index of last successful writer
- busy  out  1  high in GRANT or ACK
- q  out  WIDTH  stored register value (flip-flop output)
- wr_count  out  CNTW  completed writes, wraps modulo 2^CNTW

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ptr=0, gnt=0, ack=0, busy=0, owner=0, q=0, wr_count=0. Takes effect without a clock edge, including mid-transaction.
- State machine: IDLE -> GRANT -> ACK -> IDLE (2-bit state).
- IDLE:
  - If any req is set, pick winner w = first i with req[i]=1, searching ptr, ptr+1, ... mod NREQ.
  - Next edge: state=GRANT, gnt=onehot(w), busy=1. Otherwise stay in IDLE with gnt=0.
- GRANT:
  - If req[w]=1: register enable=1 (combinational) and register D=data[w].
  - Next edge: q<=data[w], owner<=w, wr_count<=wr_count+1, ptr<=(w+1) mod NREQ, state=ACK, ack=1, gnt held.
  - If req[w]=0 (abandon): next edge state=IDLE, gnt=0, no write, ptr/owner/wr_count unchanged.
- ACK: ack=1 for exactly this cycle. Next edge: state=IDLE, gnt=0, ack=0, busy=0.
- Latency from req sampled in IDLE:
  - gnt after 1 edge; q updated and ack high after 2 edges; gnt low after 3 edges.
  - Back-to-back throughput is one write per 3 cycles.
- Register enable is asserted only in GRANT with req[w] held. q never changes in any other state.
- Requester must hold data[w] stable while gnt[w]=1. Data of non-granted requesters is ignored.
- Changes on req for non-winners during GRANT/ACK have no effect. Arbitration happens only in IDLE.
- Fairness: a requester holding req is granted within NREQ transactions.
- wr_count wraps from 2^CNTW-1 to 0 without a flag.
- gnt is always one-hot or zero; gnt!=0 exactly when busy=1.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_GRANT=2'd1, ST_ACK=2'd2 (2'd3 is illegal; recover to IDLE)
  - default NREQ/WIDTH/CNTW values
- One sub-module, ff_enable_reg: parameterised WIDTH-bit D flip-flop with enable and the same async active-low reset. It holds q and is instanced once.
- Round-robin pick is a combinational function in the package.

Test Plan:
- Reset: drive reset=0 with req=1111 -> q=0000, gnt=0000, ack=0, busy=0, wr_count=0. Release reset -> gnt=0001 after 1 edge.
- Single write: req=0010, data1=4'b1011 -> gnt=0010 at edge 1; q=1011, ack=1, owner=1 at edge 2; gnt=0000, ack=0 at edge 3; wr_count=1.
- Contention: req=1111 held, distinct data per requester:
  - gnt sequence 0001, 0010, 0100, 1000, 0001, one grant every 3 cycles.
  - q follows data0, data1, data2, data3.
- Abandon: while gnt=0100, drop req[2] -> next edge gnt=0000, no ack, q unchanged, and the next grant search starts from the same ptr.
- Async reset mid-ACK: pull reset low between edges during ack=1 -> q=0000, gnt=0000, ack=0 immediately, before any clock edge.
- Counter wrap: 256 completed writes with CNTW=8 -> wr_count returns to 0; q equals the last written data.
